// File: rtl/mult.sv
// Sequential signed WIDTH x WIDTH multiplier, iterative radix-4 Booth, one partial product per clock.
// Free-running LOAD -> ITER -> WRITE loop; {higher, lower} holds the last product.
module mult #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] lower,
   output logic [WIDTH-1:0] higher,
   output logic             done
);

   localparam int unsigned ITERS = WIDTH / 2;
   localparam int unsigned CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

   typedef enum logic [1:0] {
      LOAD,
      ITER,
      WRITE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH+1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic             tail;
   logic [WIDTH+1:0] pp;
   logic [WIDTH+1:0] sum;
   logic             last_iter;

   assign last_iter = (cnt == CW'(ITERS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    state_nxt = ITER;
         ITER:    if (last_iter) state_nxt = WRITE;
         WRITE:   state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase
   end

   // Booth digit from {b[2i+1], b[2i], b[2i-1]}; acc_lo's low bits hold the current pair
   always_comb begin
      pp = '0;
      case ({acc_lo[1:0], tail})
         3'b001, 3'b010: pp = {{2{mcand[WIDTH-1]}}, mcand};
         3'b011:         pp = {mcand[WIDTH-1], mcand, 1'b0};
         3'b100:         pp = -{mcand[WIDTH-1], mcand, 1'b0};
         3'b101, 3'b110: pp = -{{2{mcand[WIDTH-1]}}, mcand};
         default:        pp = '0;
      endcase
   end

   assign sum = acc_hi + pp;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         mcand  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         tail   <= 1'b0;
         lower  <= '0;
         higher <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            LOAD: begin
               mcand  <= a;
               acc_lo <= b;
               acc_hi <= '0;
               tail   <= 1'b0;
               cnt    <= '0;
            end
            ITER: begin
               {acc_hi, acc_lo} <= $signed({sum, acc_lo}) >>> 2;
               tail             <= acc_lo[1];
               cnt              <= cnt + CW'(1);
            end
            WRITE: begin
               higher <= acc_hi[WIDTH-1:0];
               lower  <= acc_lo;
               done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult.sv
// Bench for mult: a timing-level product model checked every cycle, plus hand-computed
// products pinned to specific done pulses.
module tb_mult;

   localparam int W   = 32;
   localparam int PER = W / 2 + 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [W-1:0]  lower;
   logic [W-1:0]  higher;
   logic          done;

   mult #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .a     (a),
      .b     (b),
      .lower (lower),
      .higher(higher),
      .done  (done)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] prod(input logic [W-1:0] x, input logic [W-1:0] y);
      longint px;
      longint py;
      px = longint'($signed(x));
      py = longint'($signed(y));
      return px * py;
   endfunction

   // model: edges counted from the last reset edge; capture at n%PER==1, publish at n%PER==0
   bit           mvalid = 1'b0;
   int           ecnt;
   logic [63:0]  cap;
   logic [63:0]  exp_p;
   logic         exp_done;

   always @(posedge clk) begin : model
      int n;
      if (rst) begin
         mvalid   <= 1'b1;
         ecnt     <= 0;
         exp_p    <= '0;
         exp_done <= 1'b0;
      end else begin
         n = ecnt + 1;
         ecnt <= n;
         if (n % PER == 1) cap <= prod(a, b);
         if (n % PER == 0) exp_p <= cap;
         exp_done <= (n % PER == 0);
      end
   end

   // literal expectations, written by stimulus only, consumed by the compare process
   int           lit_idx [0:63];
   logic [63:0]  lit_val [0:63];
   int           lit_wr = 0;
   int           lit_rd = 0;
   int           tmo_cnt = 0;
   int           tmo_seen = 0;
   bit           fin = 1'b0;

   int           n_cmp = 0;
   int           n_bad = 0;
   int           dn_cnt = 0;
   int           cyc = 0;

   always @(negedge clk) begin
      cyc++;
      if (mvalid) begin
         n_cmp++;
         if (done !== exp_done) begin
            n_bad++;
            $display("FAIL done cyc=%0d got=%b want=%b", cyc, done, exp_done);
         end
         n_cmp++;
         if ({higher, lower} !== exp_p) begin
            n_bad++;
            $display("FAIL product cyc=%0d got=%h want=%h", cyc, {higher, lower}, exp_p);
         end
         if (done === 1'b1) begin
            dn_cnt++;
            if (lit_rd < lit_wr && lit_idx[lit_rd] == dn_cnt) begin
               n_cmp++;
               if ({higher, lower} !== lit_val[lit_rd]) begin
                  n_bad++;
                  $display("FAIL literal#%0d pulse=%0d got=%h want=%h",
                           lit_rd, dn_cnt, {higher, lower}, lit_val[lit_rd]);
               end
               lit_rd++;
            end
         end
      end
      if (tmo_cnt != tmo_seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout cyc=%0d got=no_pulse want=pulse", cyc);
         tmo_seen = tmo_cnt;
      end
      if (fin) begin
         n_cmp++;
         if (lit_rd != lit_wr) begin
            n_bad++;
            $display("FAIL literals_consumed got=%0d want=%0d", lit_rd, lit_wr);
         end
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
         $finish;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      do begin
         step();
         k++;
      end while (done !== 1'b1 && k < 100);
      if (done !== 1'b1) tmo_cnt++;
   endtask

   // called in the cycle after a WRITE, so the operands reach the next LOAD edge
   task automatic apply(input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit lit, input logic [63:0] ev);
      wait_done();
      a = x;
      b = y;
      if (lit) begin
         lit_idx[lit_wr] = dn_cnt + 2;
         lit_val[lit_wr] = ev;
         lit_wr++;
      end
   endtask

   initial begin
      a = 32'hFFFF_FFFE;
      b = 32'd3;
      rst = 1'b1;
      step();
      rst = 1'b0;
      lit_idx[0] = 1;
      lit_val[0] = 64'hFFFF_FFFF_FFFF_FFFA;
      lit_wr = 1;

      apply(32'd7,         32'd6,         1'b1, 64'd42);
      apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1);
      apply(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
      apply(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000);
      apply(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'h3FFF_FFFF_0000_0001);

      // operand change mid-flight: 5*3 first, 9*3 on the following result
      apply(32'd5, 32'd3, 1'b1, 64'd15);
      repeat (5) step();
      a = 32'd9;
      lit_idx[lit_wr] = dn_cnt + 2;
      lit_val[lit_wr] = 64'd27;
      lit_wr++;
      wait_done();

      // reset mid-ITER; the pending literal lands on the first post-reset result
      apply(32'hFFFF_FF85, 32'd456, 1'b1, 64'hFFFF_FFFF_FFFF_24E8);
      repeat (6) step();
      rst = 1'b1;
      step();
      rst = 1'b0;

      for (int i = 0; i < 1000; i++) begin
         apply($urandom, $urandom, 1'b0, 64'd0);
      end
      wait_done();
      repeat (3) step();
      fin = 1'b1;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
